// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} mem_arb_state_e;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_e;

  localparam int unsigned MEM_ARB_NUM_PORTS      = 2;
  localparam int unsigned MEM_ARB_ADDR_WIDTH     = 32;
  localparam int unsigned MEM_ARB_DATA_WIDTH     = 32;
  localparam int unsigned MEM_ARB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans from last_grant_i+1 upward
// (wrapping at NUM_PORTS) and reports the first active requester.
module rr_picker #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] active_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     winner_o
);

  // First active port after last_grant_i in circular order
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] sel;
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = 32'(last_grant_i) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      sel = IDX_W'(idx);
      if (!found_o && active_i[sel]) begin
        found_o  = 1'b1;
        winner_o = sel;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing one registered memory bus between NUM_PORTS
// requesters using level-held requests and a 4-phase ready/done handshake.
// Optional: define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES
// with a one-hot req_error response.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = MEM_ARB_NUM_PORTS,
  parameter int unsigned ADDR_WIDTH     = MEM_ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = MEM_ARB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_CYCLES,
  localparam int unsigned GW            = $clog2(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            req_done,
  output logic [NUM_PORTS-1:0]            req_error,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_ready,
  input  logic                            mem_done,
  output logic [GW-1:0]                   grant_id
);

  mem_arb_state_e          state_q;
  mem_op_e                 op_q;
  logic [GW-1:0]           g_q;
  logic [GW-1:0]           last_grant_q;
  logic                    discard_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [DATA_WIDTH-1:0]   req_rdata_q;
  logic [NUM_PORTS-1:0]    req_ready_q;
  logic [NUM_PORTS-1:0]    req_done_q;

  logic [NUM_PORTS-1:0]    active;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic                    mem_complete;
  logic                    discard_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 8) ? 8 : CW_RAW;
  logic [CW-1:0]           cnt_q;
  logic [NUM_PORTS-1:0]    req_error_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign active = req_read | req_write;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (GW)
  ) u_picker (
    .active_i     (active),
    .last_grant_i (last_grant_q),
    .found_o      (pick_found),
    .winner_o     (pick_idx)
  );

  // Route the winning port's address and write data to the latch inputs
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == GW'(i)) begin
        pick_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Completion qualifier for the current op, and response-discard decision
  always_comb begin
    mem_complete = (op_q == OP_WRITE) ? mem_done : mem_ready;
    discard_d    = discard_q | ~active[g_q];
  end

  // Arbiter FSM with registered memory-side and response outputs.
  // A request dropped during BUSY keeps the memory strobe up until the
  // memory completes, then returns straight to IDLE with no response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_READ;
      g_q           <= '0;
      last_grant_q  <= GW'(NUM_PORTS - 1);
      discard_q     <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      req_rdata_q   <= '0;
      req_ready_q   <= '0;
      req_done_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      req_error_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            g_q           <= pick_idx;
            mem_address_q <= pick_addr;
            mem_wdata_q   <= pick_wdata;
            discard_q     <= 1'b0;
            if (req_write[pick_idx]) begin
              op_q        <= OP_WRITE;
              mem_write_q <= 1'b1;
            end else begin
              op_q        <= OP_READ;
              mem_read_q  <= 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_complete) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            last_grant_q <= g_q;
            if (discard_d) begin
              state_q <= IDLE;
            end else begin
              if (op_q == OP_READ) begin
                req_rdata_q      <= mem_rdata;
                req_ready_q[g_q] <= 1'b1;
              end else begin
                req_done_q[g_q]  <= 1'b1;
              end
              state_q <= RELEASE;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            last_grant_q <= g_q;
            if (discard_d) begin
              state_q <= IDLE;
            end else begin
              req_error_q[g_q] <= 1'b1;
              state_q          <= RELEASE;
            end
          end
`endif
          else begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
            if (!active[g_q]) discard_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (!active[g_q]) begin
            req_rdata_q <= '0;
            req_ready_q <= '0;
            req_done_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            req_error_q <= '0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign req_rdata   = req_rdata_q;
  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;
  assign grant_id    = (state_q == IDLE) ? '0 : g_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign req_error   = req_error_q;
`else
  assign req_error   = '0;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter (3 ports).
module tb_mem_request_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic             clock;
  logic             reset;
  logic [NP-1:0]    req_read;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_address;
  logic [NP*DW-1:0] req_wdata;
  logic [DW-1:0]    req_rdata;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_done;
  logic [NP-1:0]    req_error;
  logic [AW-1:0]    mem_address;
  logic             mem_read;
  logic             mem_write;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             mem_ready;
  logic             mem_done;
  logic [1:0]       grant_id;

  int pass_cnt;
  int total_cnt;

  mem_request_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_rdata   (req_rdata),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .req_error   (req_error),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_done    (mem_done),
    .grant_id    (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_read    = '0;
    req_write   = '0;
    mem_ready   = 1'b0;
    mem_done    = 1'b0;
    mem_rdata   = '0;
    req_address = '0;
    req_wdata   = '0;
    req_address[0*AW +: AW] = 32'h0000_0100;
    req_address[1*AW +: AW] = 32'h0000_0200;
    req_address[2*AW +: AW] = 32'h0000_0300;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write});
    else pass_cnt++;
    total_cnt++;
    if ({req_ready, req_done, req_error} !== 9'h000) $display("FAIL reset_resp: got %h expected 000", {req_ready, req_done, req_error});
    else pass_cnt++;
    total_cnt++;
    if ({grant_id, mem_address, req_rdata} !== 66'h0) $display("FAIL reset_regs: got %h expected 0", {grant_id, mem_address, req_rdata});
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    do_reset();
    req_read = 3'b001;
    tick();
    total_cnt++;
    if ({mem_read, mem_write, grant_id} !== 4'b1000) $display("FAIL rd_issue: got %b expected 1000", {mem_read, mem_write, grant_id});
    else pass_cnt++;
    total_cnt++;
    if (mem_address !== 32'h0000_0100) $display("FAIL rd_addr: got %h expected 00000100", mem_address);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({mem_read, req_ready} !== 4'b1000) $display("FAIL rd_wait: got %b expected 1000", {mem_read, req_ready});
    else pass_cnt++;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    total_cnt++;
    if ({mem_read, req_ready} !== 4'b0001) $display("FAIL rd_ready: got %b expected 0001", {mem_read, req_ready});
    else pass_cnt++;
    total_cnt++;
    if (req_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", req_rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({req_ready, req_rdata} !== {3'b001, 32'hDEAD_BEEF}) $display("FAIL rd_hold: got %h expected 1deadbeef", {req_ready, req_rdata});
    else pass_cnt++;
    req_read = 3'b000;
    tick();
    total_cnt++;
    if ({req_ready, req_rdata} !== 35'h0) $display("FAIL rd_clear: got %h expected 0", {req_ready, req_rdata});
    else pass_cnt++;
  endtask

  task automatic test_tie();
    do_reset();
    req_read = 3'b011;
    tick();
    total_cnt++;
    if ({grant_id, mem_address} !== {2'd0, 32'h0000_0100}) $display("FAIL tie_first: got %h expected 000000100", {grant_id, mem_address});
    else pass_cnt++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req_read  = 3'b010;
    tick();
    total_cnt++;
    if ({grant_id, mem_read, req_ready} !== 6'b000000) $display("FAIL tie_gap: got %b expected 000000", {grant_id, mem_read, req_ready});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({grant_id, mem_read, mem_address} !== {2'd1, 1'b1, 32'h0000_0200}) $display("FAIL tie_second: got %h expected 300000200", {grant_id, mem_read, mem_address});
    else pass_cnt++;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_BBBB;
    tick();
    mem_ready = 1'b0;
    total_cnt++;
    if ({req_ready, req_rdata} !== {3'b010, 32'h0000_BBBB}) $display("FAIL tie_resp: got %h expected 20000bbbb", {req_ready, req_rdata});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] bit_exp;
    do_reset();
    req_read  = 3'b111;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    for (int t = 0; t < 6; t++) begin
      bit_exp = 3'b001 << (t % 3);
      tick();
      total_cnt++;
      if (grant_id !== 2'(t % 3)) $display("FAIL rr_grant%0d: got %0d expected %0d", t, grant_id, t % 3);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (req_ready !== bit_exp) $display("FAIL rr_ready%0d: got %b expected %b", t, req_ready, bit_exp);
      else pass_cnt++;
      req_read = 3'b111 & ~bit_exp;
      tick();
      req_read = 3'b111;
    end
    mem_ready = 1'b0;
    req_read  = 3'b000;
  endtask

  task automatic test_write();
    do_reset();
    req_address[1*AW +: AW] = 32'h0000_0040;
    req_wdata[1*DW +: DW]   = 32'h1234_5678;
    req_write = 3'b010;
    req_read  = 3'b010;
    tick();
    total_cnt++;
    if ({mem_write, mem_read, grant_id} !== 4'b1001) $display("FAIL wr_issue: got %b expected 1001", {mem_write, mem_read, grant_id});
    else pass_cnt++;
    total_cnt++;
    if ({mem_address, mem_wdata} !== {32'h0000_0040, 32'h1234_5678}) $display("FAIL wr_bus: got %h expected 0000004012345678", {mem_address, mem_wdata});
    else pass_cnt++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total_cnt++;
    if ({mem_write, req_ready, req_done} !== 7'b1000000) $display("FAIL wr_ignore_ready: got %b expected 1000000", {mem_write, req_ready, req_done});
    else pass_cnt++;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    total_cnt++;
    if ({mem_write, req_ready, req_done} !== 7'b0000010) $display("FAIL wr_done: got %b expected 0000010", {mem_write, req_ready, req_done});
    else pass_cnt++;
    req_write = 3'b000;
    req_read  = 3'b000;
    tick();
    total_cnt++;
    if (req_done !== 3'b000) $display("FAIL wr_clear: got %b expected 000", req_done);
    else pass_cnt++;
  endtask

  task automatic test_drop_in_busy();
    do_reset();
    req_read = 3'b011;
    tick();
    req_read = 3'b010;
    tick();
    total_cnt++;
    if ({mem_read, grant_id} !== 3'b100) $display("FAIL drop_mem_held: got %b expected 100", {mem_read, grant_id});
    else pass_cnt++;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ready = 1'b0;
    total_cnt++;
    if ({mem_read, req_ready, grant_id} !== 6'b000000) $display("FAIL drop_discard: got %b expected 000000", {mem_read, req_ready, grant_id});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mem_read, grant_id, mem_address} !== {1'b1, 2'd1, 32'h0000_0200}) $display("FAIL drop_next: got %h expected 300000200", {mem_read, grant_id, mem_address});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    req_read = 3'b100;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) tick();
    total_cnt++;
    if ({mem_read, req_error} !== 4'b1000) $display("FAIL to_before: got %b expected 1000", {mem_read, req_error});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mem_read, req_error} !== 4'b0100) $display("FAIL to_abort: got %b expected 0100", {mem_read, req_error});
    else pass_cnt++;
`else
    for (int i = 0; i < 20; i++) tick();
    total_cnt++;
    if ({mem_read, req_error, grant_id} !== 6'b100010) $display("FAIL to_hold: got %b expected 100010", {mem_read, req_error, grant_id});
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_in_busy();
    do_reset();
    req_read  = 3'b001;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    req_read  = 3'b000;
    tick();
    req_read  = 3'b011;
    tick();
    total_cnt++;
    if ({grant_id, mem_read} !== 3'b011) $display("FAIL rb_grant1: got %b expected 011", {grant_id, mem_read});
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({mem_read, mem_write, req_ready, req_done, req_error, grant_id} !== 13'h0) $display("FAIL rb_cleared: got %b expected 0", {mem_read, mem_write, req_ready, req_done, req_error, grant_id});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({grant_id, mem_read, mem_address} !== {2'd0, 1'b1, 32'h0000_0100}) $display("FAIL rb_favour0: got %h expected 100000100", {grant_id, mem_read, mem_address});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_read();
    test_tie();
    test_round_robin();
    test_write();
    test_drop_in_busy();
    test_timeout();
    test_reset_in_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
